// File: rtl/initialization_sequence_decoder.sv
// Decodes CPU writes into single-cycle ICW1-4 / OCW1-3 strobes and tracks
// the initialization command word sequence.
module initialization_sequence_decoder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       initialization_busy
);

    typedef enum logic [1:0] {
        CMD_READY,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4
    } state_t;

    // Strobe bit positions inside r_strobe / w_strobe
    localparam int ICW1 = 0;
    localparam int ICW2 = 1;
    localparam int ICW3 = 2;
    localparam int ICW4 = 3;
    localparam int OCW1 = 4;
    localparam int OCW2 = 5;
    localparam int OCW3 = 6;

    state_t     r_state;
    state_t     w_nextState;
    logic       r_writeEnableN;
    logic       r_captureValid;
    logic       r_address;
    logic [7:0] r_data;
    logic       r_singleOrCascade;
    logic       r_setIcw4;
    logic [7:0] r_dataBus;
    logic       r_busy;
    logic [6:0] r_strobe;
    logic [6:0] w_strobe;
    logic       w_writeEvent;
    logic       w_isIcw1;

    // The write event fires on the rising edge of the strobe, after at least one capture
    assign w_writeEvent = !r_writeEnableN && write_enable_n && r_captureValid;
    assign w_isIcw1     = !r_address && r_data[4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_writeEnableN <= 1'b1;
            r_captureValid <= 1'b0;
            r_address      <= 1'b0;
            r_data         <= 8'h00;
        end else begin
            r_writeEnableN <= write_enable_n;
            if (!write_enable_n && !chip_select_n) begin
                r_address      <= address;
                r_data         <= data_bus_in;
                r_captureValid <= 1'b1;
            end else if (w_writeEvent) begin
                r_captureValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CMD_READY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_writeEvent) begin
            if (w_isIcw1) begin
                w_nextState = WAIT_ICW2;
            end else if (r_address) begin
                case (r_state)
                    WAIT_ICW2: begin
                        if (!r_singleOrCascade) begin
                            w_nextState = WAIT_ICW3;
                        end else if (r_setIcw4) begin
                            w_nextState = WAIT_ICW4;
                        end else begin
                            w_nextState = CMD_READY;
                        end
                    end
                    WAIT_ICW3: w_nextState = r_setIcw4 ? WAIT_ICW4 : CMD_READY;
                    WAIT_ICW4: w_nextState = CMD_READY;
                    default:   w_nextState = r_state;
                endcase
            end
        end
    end

    always_comb begin
        w_strobe = 7'b0;
        if (w_writeEvent) begin
            if (w_isIcw1) begin
                w_strobe[ICW1] = 1'b1;
            end else begin
                case (r_state)
                    CMD_READY: begin
                        if (r_address) begin
                            w_strobe[OCW1] = 1'b1;
                        end else if (r_data[3]) begin
                            w_strobe[OCW3] = 1'b1;
                        end else begin
                            w_strobe[OCW2] = 1'b1;
                        end
                    end
                    WAIT_ICW2: w_strobe[ICW2] = r_address;
                    WAIT_ICW3: w_strobe[ICW3] = r_address;
                    WAIT_ICW4: w_strobe[ICW4] = r_address;
                    default:   w_strobe = 7'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe          <= 7'b0;
            r_dataBus         <= 8'h00;
            r_busy            <= 1'b0;
            r_singleOrCascade <= 1'b1;
            r_setIcw4         <= 1'b0;
        end else begin
            r_strobe <= w_strobe;
            r_busy   <= (w_nextState != CMD_READY);
            if (w_writeEvent) begin
                r_dataBus <= r_data;
            end
            if (w_writeEvent && w_isIcw1) begin
                r_singleOrCascade <= r_data[1];
                r_setIcw4         <= r_data[0];
            end
        end
    end

    assign internal_data_bus              = r_dataBus;
    assign initialization_busy            = r_busy;
    assign write_initial_command_word_1   = r_strobe[ICW1];
    assign write_initial_command_word_2   = r_strobe[ICW2];
    assign write_initial_command_word_3   = r_strobe[ICW3];
    assign write_initial_command_word_4   = r_strobe[ICW4];
    assign write_operation_control_word_1 = r_strobe[OCW1];
    assign write_operation_control_word_2 = r_strobe[OCW2];
    assign write_operation_control_word_3 = r_strobe[OCW3];

endmodule

// File: tb/tb_initialization_sequence_decoder.sv
// Self-checking bench: directed sequences plus random writes compared against
// a queue-based model of the pending initialization command words.
module tb_initialization_sequence_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       chip_select_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       address = 1'b0;
    logic [7:0] data_bus_in = 8'h00;
    logic [7:0] internal_data_bus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       initialization_busy;
    logic [6:0] obsStrobe;

    int checkCount = 0;
    int errorCount = 0;

    // Model: list of ICW numbers still expected, and the last accepted data
    int         pending[$];
    logic [7:0] expBus = 8'h00;

    initialization_sequence_decoder dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .chip_select_n                  (chip_select_n),
        .write_enable_n                 (write_enable_n),
        .address                        (address),
        .data_bus_in                    (data_bus_in),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .initialization_busy            (initialization_busy)
    );

    assign obsStrobe = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Strobe bit order: icw1..icw4 = bits 0..3, ocw1..ocw3 = bits 4..6
    task automatic modelWrite(input logic a, input logic [7:0] d, output logic [6:0] expStrobe);
        expStrobe = 7'b0;
        expBus = d;
        if (!a && d[4]) begin
            pending.delete();
            pending.push_back(2);
            if (!d[1]) pending.push_back(3);
            if (d[0]) pending.push_back(4);
            expStrobe[0] = 1'b1;
        end else if (pending.size() == 0) begin
            if (a) expStrobe[4] = 1'b1;
            else if (d[3]) expStrobe[6] = 1'b1;
            else expStrobe[5] = 1'b1;
        end else if (a) begin
            expStrobe[pending.pop_front() - 1] = 1'b1;
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".strobe"}, {25'b0, obsStrobe}, 32'h0);
        checkOutput({tag, ".bus"}, {24'b0, internal_data_bus}, {24'b0, expBus});
        checkOutput({tag, ".busy"}, {31'b0, initialization_busy}, {31'b0, pending.size() != 0});
    endtask

    task automatic applyStimulus(input logic a, input logic [7:0] d, input logic csN, input int lowCycles);
        logic [6:0] expStrobe;
        @(negedge clock);
        address = a;
        data_bus_in = d;
        chip_select_n = csN;
        write_enable_n = 1'b0;
        for (int i = 0; i < lowCycles; i++) begin
            @(negedge clock);
            checkOutput("strobeDuringLow", {25'b0, obsStrobe}, 32'h0);
        end
        write_enable_n = 1'b1;
        if (csN) expStrobe = 7'b0;
        else modelWrite(a, d, expStrobe);
        @(negedge clock);
        checkOutput("strobe", {25'b0, obsStrobe}, {25'b0, expStrobe});
        checkOutput("bus", {24'b0, internal_data_bus}, {24'b0, expBus});
        checkOutput("busy", {31'b0, initialization_busy}, {31'b0, pending.size() != 0});
        chip_select_n = 1'b1;
        data_bus_in = 8'($urandom);
        @(negedge clock);
        checkIdle("afterStrobe");
    endtask

    task automatic write(input logic a, input logic [7:0] d);
        applyStimulus(a, d, 1'b0, 2 + int'($urandom_range(0, 2)));
    endtask

    // Reset lands asynchronously in the middle of a write low period
    task automatic resetMidWrite();
        @(negedge clock);
        address = 1'b1;
        data_bus_in = 8'($urandom);
        chip_select_n = 1'b0;
        write_enable_n = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        pending.delete();
        expBus = 8'h00;
        #1;
        checkIdle("asyncReset");
        @(negedge clock);
        write_enable_n = 1'b1;
        chip_select_n = 1'b1;
        @(negedge clock);
        checkIdle("inReset");
        reset_n = 1'b1;
        @(negedge clock);
        checkIdle("afterReset");
    endtask

    initial begin
        logic [7:0] d;
        logic       a;
        int         kind;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        checkOutput("resetBus", {24'b0, internal_data_bus}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single, ICW4 needed
        write(1'b0, 8'h13);
        write(1'b1, 8'h20);
        write(1'b1, 8'h01);
        checkOutput("seq1Bus", {24'b0, internal_data_bus}, 32'h01);
        checkOutput("seq1Busy", {31'b0, initialization_busy}, 32'h0);

        // Cascade, ICW4 needed
        write(1'b0, 8'h11);
        write(1'b1, 8'h08);
        write(1'b1, 8'h04);
        write(1'b1, 8'h01);
        checkOutput("seq2Busy", {31'b0, initialization_busy}, 32'h0);

        // Single, no ICW4, then OCW1
        write(1'b0, 8'h12);
        write(1'b1, 8'h40);
        write(1'b1, 8'hFF);

        // OCW2 / OCW3 in command mode, ignored A0=0 write while waiting for ICW2
        write(1'b0, 8'h20);
        write(1'b0, 8'h0B);
        write(1'b0, 8'h13);
        write(1'b0, 8'h20);
        checkOutput("heldBusy", {31'b0, initialization_busy}, 32'h1);
        write(1'b1, 8'h20);
        write(1'b1, 8'h01);

        // Deselected write has no effect
        applyStimulus(1'b1, 8'h55, 1'b1, 3);

        // Restart from WAIT_ICW3, then reset in WAIT_ICW4
        write(1'b0, 8'h11);
        write(1'b1, 8'h08);
        write(1'b0, 8'h13);
        write(1'b0, 8'h11);
        write(1'b1, 8'h08);
        write(1'b1, 8'h04);
        resetMidWrite();
        write(1'b1, 8'h77);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 99));
            d = 8'($urandom);
            if (kind < 3) begin
                resetMidWrite();
            end else if (kind < 10) begin
                applyStimulus(1'($urandom), d, 1'b1, 2 + int'($urandom_range(0, 2)));
            end else begin
                if (kind < 30) begin
                    a = 1'b0;
                    d[4] = 1'b1;
                end else if (kind < 70) begin
                    a = 1'b1;
                end else begin
                    a = 1'b0;
                    d[4] = 1'b0;
                end
                write(a, d);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/initialization_sequence_decoder.md
INITIALIZATION_SEQUENCE_DECODER -- requirements
Module: initialization_sequence_decoder

Interface
REQ-001 SHALL have ports: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: chip_select_n  input  1  active-low device select.
REQ-004 SHALL have ports: write_enable_n  input  1  active-low CPU write strobe, asynchronous to clock, each low period at least 2 clocks.
REQ-005 SHALL have ports: address  input  1  A0 register select.
REQ-006 SHALL have ports: data_bus_in  input  8  CPU data.
REQ-007 SHALL have ports: internal_data_bus  output  8  data of the last accepted write.
REQ-008 SHALL have ports: write_initial_command_word_1 through write_initial_command_word_4  output  1 each  single-cycle ICW strobes.
REQ-009 SHALL have ports: write_operation_control_word_1 through write_operation_control_word_3  output  1 each  single-cycle OCW strobes.
REQ-010 SHALL have ports: initialization_busy  output  1  high while any ICW2/3/4 is still expected.

Function
REQ-011 SHALL capture address and data_bus_in into internal registers on every clock edge where write_enable_n and chip_select_n are both low; the capture also sets a capture-valid flag.
REQ-012 SHALL register write_enable_n; a write event is a clock edge where the registered value is 0, the current value is 1, and capture-valid is set; capture-valid clears at that edge.
REQ-013 SHALL, on a write event, drive the decoded strobe high for exactly one cycle starting at that edge; all other strobes stay low; at most one strobe is high in any cycle.
REQ-014 SHALL drive internal_data_bus with the captured data from the write-event edge, holding it until the next write event.
REQ-015 SHALL implement states CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
REQ-016 Decode, any state: A0=0 and D4=1 -> ICW1 strobe; latch single_or_cascade=D1 and set_icw4=D0; next state WAIT_ICW2. This restarts initialization from any state.
REQ-017 Decode in CMD_READY: A0=1 -> OCW1; A0=0, D4=0, D3=0 -> OCW2; A0=0, D4=0, D3=1 -> OCW3; state unchanged.
REQ-018 WAIT_ICW2, A0=1: ICW2 strobe. Next state is WAIT_ICW3 if single_or_cascade=0; else WAIT_ICW4 if set_icw4=1; else CMD_READY.
REQ-019 WAIT_ICW3, A0=1: ICW3 strobe. Next state is WAIT_ICW4 if set_icw4=1, else CMD_READY.
REQ-020 WAIT_ICW4, A0=1: ICW4 strobe; next state CMD_READY.
REQ-021 In a WAIT state, a write with A0=0 and D4=0 SHALL produce no strobe and leave the state unchanged; internal_data_bus still updates.
REQ-022 A strobe that ends while chip_select_n is high throughout the low period SHALL be ignored, with no capture and no event.
REQ-023 initialization_busy SHALL be high exactly when the state is not CMD_READY, registered and updating at the same edge as the state.

Reset
REQ-024 While reset_n=0, the block SHALL hold: state CMD_READY; all strobes 0; internal_data_bus 8'h00; registered write_enable_n 1; capture-valid 0; single_or_cascade 1; set_icw4 0; initialization_busy 0.
REQ-025 Reset asserted mid-write or mid-sequence SHALL abort immediately with no strobe; the first write after release is decoded from CMD_READY.

Verification
REQ-026 ICW1=8'h13 (single, ICW4), then A0=1 8'h20, then A0=1 8'h01 -> ICW1, ICW2, ICW4 strobes one cycle each; no ICW3; busy 1->1->0; internal_data_bus ends at 8'h01.
REQ-027 ICW1=8'h11 (cascade, ICW4), then A0=1 writes 8'h08, 8'h04, 8'h01 -> ICW1, ICW2, ICW3, ICW4 in order; final state CMD_READY.
REQ-028 ICW1=8'h12 (single, no ICW4), then A0=1 8'h40 -> ICW2; busy falls at the ICW2 edge; a following A0=1 8'hFF -> OCW1.
REQ-029 In CMD_READY, A0=0 8'h20 -> OCW2; A0=0 8'h0B -> OCW3. In WAIT_ICW2, A0=0 8'h20 -> no strobe and state held.
REQ-030 ICW1=8'h11, ICW2 sent, then A0=0 8'h13 in WAIT_ICW3 -> ICW1 strobe and restart to WAIT_ICW2; reset_n pulsed low in WAIT_ICW4 -> all outputs at reset values and no strobe.
